waveform_line_sequencer: RTL and testbench

Upstream feeder for the line-drawing engine. Collects a frame of signed audio samples, maps each to a screen y-coordinate, then issues one line-draw request per adjacent sample pair (start/coordinates out, wait for done), producing a connected oscilloscope trace across the screen. It sits between the audio sample stream and the line-drawing engine.

---
 rtl/waveform_line_sequencer_if.sv | 25 ++
 rtl/waveform_line_sequencer.sv | 126 ++++++++++++
 tb/tb_waveform_line_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_line_sequencer_if.sv
// Sample stream, line-draw request channel and frame status between the
// waveform sequencer (master) and its producer / line engine (slave).
interface waveform_line_sequencer_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int COORD_WIDTH  = 16
);
  logic signed [SAMPLE_WIDTH-1:0] sample_in;
  logic                           sample_valid;
  logic                           sample_ready;
  logic                           line_start;
  logic signed [COORD_WIDTH-1:0]  x1, y1, x2, y2;
  logic                           line_done;
  logic                           frame_done;
  logic                           busy;

  modport master (
    input  sample_in, sample_valid, line_done,
    output sample_ready, line_start, x1, y1, x2, y2, frame_done, busy
  );

  modport slave (
    output sample_in, sample_valid, line_done,
    input  sample_ready, line_start, x1, y1, x2, y2, frame_done, busy
  );
endinterface

// File: rtl/waveform_line_sequencer.sv
// Collects a frame of audio samples as screen y-coordinates and issues one line
// request per adjacent pair. Define WAVE_CLAMP_EN to saturate y to the screen.
module waveform_line_sequencer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SAMPLE_WIDTH  = 24,
  parameter int COORD_WIDTH   = 16,
  parameter int NUM_POINTS    = 64,
  parameter int X_STEP        = 10,
  parameter int Y_SHIFT       = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  waveform_line_sequencer_if.master  bus
);
  localparam int IDX_W     = $clog2(NUM_POINTS);
  localparam int MAP_W     = ((SAMPLE_WIDTH > COORD_WIDTH) ? SAMPLE_WIDTH : COORD_WIDTH) + 1;
  localparam int COORD_MAX = (1 << (COORD_WIDTH-1)) - 1;
  localparam logic [IDX_W-1:0]        LAST_PT  = IDX_W'(NUM_POINTS-1);
  localparam logic [IDX_W-1:0]        LAST_SEG = IDX_W'(NUM_POINTS-2);
  localparam logic signed [MAP_W-1:0] HALF_H   = MAP_W'(SCREEN_HEIGHT/2);
  localparam logic signed [MAP_W-1:0] Y_MAX    = MAP_W'(SCREEN_HEIGHT-1);

  // x is never clamped, so the widest trace and the screen must fit the coordinate type.
  if (NUM_POINTS < 2 || (NUM_POINTS-1)*X_STEP > COORD_MAX ||
      SCREEN_WIDTH-1 > COORD_MAX || SCREEN_HEIGHT-1 > COORD_MAX) begin : g_cfg_err
    $error("waveform_line_sequencer: parameters do not fit COORD_WIDTH");
  end

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_FDONE} state_t;

  state_t                         state, state_nx;
  logic [IDX_W-1:0]               wr_idx, wr_nx, seg_idx, seg_nx, seg_p1;
  logic                           accept;
  logic signed [COORD_WIDTH-1:0]  pbuf [NUM_POINTS];
  logic signed [MAP_W-1:0]        s_ext, s_shr, y_full;
  logic signed [COORD_WIDTH-1:0]  y_store, x1_nx, y1_nx, x2_nx, y2_nx;

  always_comb begin
    s_ext  = {{(MAP_W-SAMPLE_WIDTH){bus.sample_in[SAMPLE_WIDTH-1]}}, bus.sample_in};
    s_shr  = s_ext >>> Y_SHIFT;
    y_full = HALF_H - s_shr;
`ifdef WAVE_CLAMP_EN
    if (y_full < 0)          y_store = '0;
    else if (y_full > Y_MAX) y_store = COORD_WIDTH'(Y_MAX);
    else                     y_store = COORD_WIDTH'(y_full);
`else
    y_store = COORD_WIDTH'(y_full);
`endif
  end

  always_comb begin
    state_nx = state;
    wr_nx    = wr_idx;
    seg_nx   = seg_idx;
    accept   = 1'b0;
    case (state)
      S_FILL: if (bus.sample_valid) begin
        accept = 1'b1;
        if (wr_idx == LAST_PT) begin
          state_nx = S_ISSUE;
          seg_nx   = '0;
        end else begin
          wr_nx = wr_idx + 1'b1;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: if (bus.line_done) begin
        if (seg_idx == LAST_SEG) state_nx = S_FDONE;
        else begin
          seg_nx   = seg_idx + 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_FDONE: begin
        wr_nx    = '0;
        state_nx = S_FILL;
      end
      default: state_nx = S_FILL;
    endcase
  end

  // Endpoints are loaded on entry to Issue; the last sample is still being
  // written on that edge, so it is forwarded when it is the far endpoint.
  always_comb begin
    seg_p1 = seg_nx + 1'b1;
    x1_nx  = COORD_WIDTH'(int'(seg_nx) * X_STEP);
    x2_nx  = COORD_WIDTH'(int'(seg_p1) * X_STEP);
    y1_nx  = pbuf[seg_nx];
    y2_nx  = (accept && wr_idx == seg_p1) ? y_store : pbuf[seg_p1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_FILL;
      wr_idx           <= '0;
      seg_idx          <= '0;
      bus.sample_ready <= 1'b1;
      bus.busy         <= 1'b0;
      bus.line_start   <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.x1           <= '0;
      bus.y1           <= '0;
      bus.x2           <= '0;
      bus.y2           <= '0;
    end else begin
      state            <= state_nx;
      wr_idx           <= wr_nx;
      seg_idx          <= seg_nx;
      bus.sample_ready <= (state_nx == S_FILL);
      bus.busy         <= (state_nx != S_FILL);
      bus.line_start   <= (state_nx == S_ISSUE);
      bus.frame_done   <= (state_nx == S_FDONE);
      if (state_nx == S_ISSUE) begin
        bus.x1 <= x1_nx;
        bus.y1 <= y1_nx;
        bus.x2 <= x2_nx;
        bus.y2 <= y2_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pbuf[wr_idx] <= y_store;
  end
endmodule

// File: tb/tb_waveform_line_sequencer.sv
// Directed bench for waveform_line_sequencer: frames of samples in, line
// requests served by an in-line engine model, coordinates checked by hand.
module tb_waveform_line_sequencer;
  localparam int NP = 64;
`ifdef WAVE_CLAMP_EN
  localparam int Y_POS_FS = 0;
  localparam int Y_NEG_FS = 479;
`else
  localparam int Y_POS_FS = -15;
  localparam int Y_NEG_FS = 496;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  waveform_line_sequencer_if #(.SAMPLE_WIDTH(24), .COORD_WIDTH(16)) bus ();

  waveform_line_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ls_total = 0;
  int fd_total = 0;

  logic signed [23:0] prod_vals[$];
  int prod_idx = 0;

  int sx1[NP], sy1[NP], sx2[NP], sy2[NP];
  int nseg, unstable, rdy_busy;

  always @(negedge clk) begin
    if (bus.line_start === 1'b1) ls_total++;
    if (bus.frame_done === 1'b1) fd_total++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_y(input logic signed [23:0] s);
    int v;
    v = 240 - (int'(s) >>> 15);
`ifdef WAVE_CLAMP_EN
    if (v < 0) v = 0;
    if (v > 479) v = 479;
`endif
    return v;
  endfunction

  task automatic drive_prod();
    if (prod_idx < prod_vals.size()) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = prod_vals[prod_idx];
    end else begin
      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;
    end
  endtask

  // Producer holds each sample until the handshake completes.
  task automatic tick();
    logic acc;
    acc = bus.sample_valid && bus.sample_ready && !reset;
    @(posedge clk);
    #1;
    if (acc) prod_idx++;
    drive_prod();
  endtask

  task automatic serve_frame(input int delay, input int abort_seg);
    int guard;
    nseg = 0; unstable = 0; rdy_busy = 0;
    for (int s = 0; s < NP-1; s++) begin
      guard = 0;
      while (bus.line_start !== 1'b1 && guard < 2000) begin
        tick();
        guard++;
      end
      if (bus.line_start !== 1'b1) begin
        chk("line_start_timeout", bus.line_start, 1);
        return;
      end
      sx1[s] = bus.x1; sy1[s] = bus.y1; sx2[s] = bus.x2; sy2[s] = bus.y2;
      nseg++;
      tick();
      if (s == abort_seg) return;
      for (int d = 0; d < delay; d++) begin
        if (bus.sample_ready !== 1'b0) rdy_busy++;
        if (bus.x1 != sx1[s] || bus.y1 != sy1[s] || bus.x2 != sx2[s] || bus.y2 != sy2[s]) unstable++;
        tick();
      end
      if (bus.x1 != sx1[s] || bus.y1 != sy1[s] || bus.x2 != sx2[s] || bus.y2 != sy2[s]) unstable++;
      bus.line_done = 1'b1;
      tick();
      bus.line_done = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    int bad;
    bad = 0;
    for (int s = 0; s < NP-1; s++) begin
      if (sy1[s] != exp_y(prod_vals[base+s]))   bad++;
      if (sy2[s] != exp_y(prod_vals[base+s+1])) bad++;
      if (sx1[s] != s*10 || sx2[s] != (s+1)*10) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic push_frame(input int seed, input int n);
    for (int i = 0; i < n; i++) prod_vals.push_back(24'((i + seed) * 123457 ^ ((i + seed) << 17)));
    drive_prod();
  endtask

  int ls0, fd0, base;

  initial begin
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    bus.line_done = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sample_ready", bus.sample_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_line_start", bus.line_start, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_x1", bus.x1, 0);
    chk("rst_y1", bus.y1, 0);
    chk("rst_x2", bus.x2, 0);
    chk("rst_y2", bus.y2, 0);
    reset = 1'b0;

    // Frame 1: all-zero samples, immediate line_done.
    ls0 = ls_total; fd0 = fd_total; base = prod_vals.size();
    for (int i = 0; i < NP; i++) prod_vals.push_back(24'sd0);
    drive_prod();
    serve_frame(0, -1);
    repeat (3) tick();
    chk("f1_segments", nseg, 63);
    chk("f1_ls_pulses", ls_total - ls0, 63);
    check_frame("f1_coords", base);
    chk("f1_y1_first", sy1[0], 240);
    chk("f1_last_x1", sx1[62], 620);
    chk("f1_last_x2", sx2[62], 630);
    chk("f1_frame_done", fd_total - fd0, 1);
    chk("f1_ready_after", bus.sample_ready, 1);

    // Frame 2 (slow engine) with frame 3 queued behind it on a held-valid stream.
    ls0 = ls_total; fd0 = fd_total; base = prod_vals.size();
    prod_vals.push_back(24'sh008000);
    prod_vals.push_back(24'sh000000);
    prod_vals.push_back(24'sh7FFFFF);
    prod_vals.push_back(24'sh800000);
    push_frame(7, NP-4);
    push_frame(300, NP);
    serve_frame(50, -1);
    chk("f2_frame_done_pulse", bus.frame_done, 1);
    chk("f2_ready_in_fdone", bus.sample_ready, 0);
    tick();
    chk("f2_ready_after_fdone", bus.sample_ready, 1);
    chk("f2_fdone_one_cycle", bus.frame_done, 0);
    chk("f2_busy_after", bus.busy, 0);
    chk("f2_seg0_x1", sx1[0], 0);
    chk("f2_seg0_y1", sy1[0], 239);
    chk("f2_seg0_x2", sx2[0], 10);
    chk("f2_seg0_y2", sy2[0], 240);
    chk("f2_seg1_y2", sy2[1], Y_POS_FS);
    chk("f2_seg2_y1", sy1[2], Y_POS_FS);
    chk("f2_seg2_y2", sy2[2], Y_NEG_FS);
    check_frame("f2_coords", base);
    chk("f2_ready_low_in_wait", rdy_busy, 0);
    chk("f2_coords_stable", unstable, 0);
    chk("f2_ls_pulses", ls_total - ls0, 63);

    // Frame 3 was already offered during frame 2.
    ls0 = ls_total; fd0 = fd_total; base = base + NP;
    serve_frame(0, -1);
    repeat (3) tick();
    check_frame("f3_coords", base);
    chk("f3_ls_pulses", ls_total - ls0, 63);
    chk("f3_frame_done", fd_total - fd0, 1);
    chk("f3_consumed", prod_idx, 3*NP);

    // Frame 4: reset while waiting on segment 10.
    push_frame(900, NP);
    serve_frame(2, 10);
    chk("f4_reached_seg10", nseg, 11);
    chk("f4_busy_in_wait", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_line_start", bus.line_start, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sample_ready", bus.sample_ready, 1);
    chk("abort_x1", bus.x1, 0);
    #2 reset = 1'b0;
    ls0 = ls_total;
    bus.line_done = 1'b1;
    tick();
    bus.line_done = 1'b0;
    repeat (5) tick();
    chk("stray_done_no_req", ls_total - ls0, 0);
    chk("stray_done_busy", bus.busy, 0);

    // Frame 5: line_done pulsed mid-fill must not disturb collection.
    ls0 = ls_total; fd0 = fd_total; base = prod_vals.size();
    push_frame(1500, 5);
    repeat (8) tick();
    bus.line_done = 1'b1;
    tick();
    bus.line_done = 1'b0;
    tick();
    chk("fill_done_line_start", bus.line_start, 0);
    chk("fill_done_ready", bus.sample_ready, 1);
    chk("fill_done_busy", bus.busy, 0);
    push_frame(1505, NP-5);
    serve_frame(1, -1);
    repeat (3) tick();
    check_frame("f5_coords", base);
    chk("f5_ls_pulses", ls_total - ls0, 63);
    chk("f5_frame_done", fd_total - fd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
